dma_dreq_agent: RTL and testbench



---
 rtl/dma_dreq_agent.sv | 204 ++++++++++++++++++++
 tb/tb_dma_dreq_agent.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_dreq_agent.sv
// dma_dreq_agent: device-side DREQ/DACK agent for an 8237A-style DMA controller.
// Device bytes are queued in a small FIFO; DREQ is raised once the level reaches
// THRESH and one byte is drained per IOR_N strobe while DACK is active. Single or
// demand release, terminal count via EOP_N.
// Optional build macro: DMA_AGENT_SYNC_EN puts DACK, IOR_N and EOP_N through a
// two-flop synchronizer, which moves every response to them two cycles later.
module dma_dreq_agent #(
    parameter int DEPTH  = 8,
    parameter int THRESH = 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   dreqActiveLow,
    input  logic                   dackActiveLow,
    input  logic                   demandMode,
    input  logic                   devValid,
    input  logic [7:0]             devData,
    output logic                   devReady,
    output logic                   DREQ,
    input  logic                   DACK,
    input  logic                   IOR_N,
    input  logic                   EOP_N,
    output logic [7:0]             DB,
    output logic                   DBEn,
    output logic [$clog2(DEPTH):0] level,
    output logic                   tcDone
);

    localparam int AW   = $clog2(DEPTH);
    localparam int LVLW = AW + 1;
    localparam logic [LVLW-1:0] FULL_LVL = LVLW'(DEPTH);
    localparam logic [LVLW-1:0] THR_LVL  = LVLW'(THRESH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t            state_q;
    logic              req_q;
    logic              tc_q;
    logic              demand_q;
    logic              ack_q;
    logic              ior_q;
    logic [AW:0]       wr_q;
    logic [AW:0]       rd_q;
    logic [7:0]        mem_q [DEPTH];

    logic              ack_in_s;
    logic              ior_in_s;
    logic              eop_in_s;
    logic [LVLW-1:0]   lvl_s;
    logic [LVLW-1:0]   lvl_next_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              eop_s;
    logic              dben_s;
    logic [7:0]        head_s;

`ifdef DMA_AGENT_SYNC_EN
    logic [1:0] ack_sync_q;
    logic [1:0] ior_sync_q;
    logic [1:0] eop_sync_q;

    // Two-flop synchronizers; reset to the inactive level of each strobe.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ack_sync_q <= 2'b00;
            ior_sync_q <= 2'b11;
            eop_sync_q <= 2'b11;
        end else begin
            ack_sync_q <= {ack_sync_q[0], DACK ^ dackActiveLow};
            ior_sync_q <= {ior_sync_q[0], IOR_N};
            eop_sync_q <= {eop_sync_q[0], EOP_N};
        end
    end

    assign ack_in_s = ack_sync_q[1];
    assign ior_in_s = ior_sync_q[1];
    assign eop_in_s = eop_sync_q[1];
`else
    assign ack_in_s = DACK ^ dackActiveLow;
    assign ior_in_s = IOR_N;
    assign eop_in_s = EOP_N;
`endif

    // FIFO occupancy and handshake decode; a pop frees a slot for a same-cycle push.
    assign lvl_s  = wr_q - rd_q;
    assign full_s = (lvl_s == FULL_LVL);
    assign head_s = mem_q[rd_q[AW-1:0]];
    assign pop_s  = (state_q == XFER) && ack_in_s && ior_in_s && !ior_q
                    && (lvl_s != {LVLW{1'b0}});
    assign push_s = devValid && (!full_s || pop_s);
    assign eop_s  = ((state_q == REQ) || (state_q == XFER)) && ack_in_s && !eop_in_s;
    assign dben_s = (state_q == XFER) && ack_q && !ior_q;

    // Level after this edge's push/pop, used for the demand-mode release decision.
    always_comb begin
        lvl_next_s = lvl_s;
        if (push_s && !pop_s) begin
            lvl_next_s = lvl_s + LVLW'(1);
        end else if (pop_s && !push_s) begin
            lvl_next_s = lvl_s - LVLW'(1);
        end else begin
            lvl_next_s = lvl_s;
        end
    end

    // Registered copies of acknowledge and read strobe for edge detect and bus drive.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ack_q <= 1'b0;
            ior_q <= 1'b1;
        end else begin
            ack_q <= ack_in_s;
            ior_q <= ior_in_s;
        end
    end

    // FIFO read and write pointers; reset empties the buffer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_s) begin
                wr_q <= wr_q + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_q <= rd_q + (AW+1)'(1);
            end
        end
    end

    // FIFO storage write port; contents need no reset since pointers gate reads.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[wr_q[AW-1:0]] <= devData;
        end
    end

    // Request FSM with registered request and terminal-count pulse.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            tc_q     <= 1'b0;
            demand_q <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (lvl_s >= THR_LVL) begin
                        demand_q <= demandMode;
                        req_q    <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (eop_s) begin
                        req_q   <= 1'b0;
                        tc_q    <= 1'b1;
                        state_q <= REL;
                    end else if (ack_in_s) begin
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (eop_s) begin
                        req_q   <= 1'b0;
                        tc_q    <= 1'b1;
                        state_q <= REL;
                    end else if (pop_s) begin
                        if (!demand_q || (lvl_next_s == {LVLW{1'b0}})) begin
                            req_q   <= 1'b0;
                            state_q <= REL;
                        end
                    end
                end
                REL: begin
                    req_q <= 1'b0;
                    if (!ack_in_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign DREQ     = req_q ^ dreqActiveLow;
    assign DBEn     = dben_s;
    assign DB       = dben_s ? head_s : 8'h00;
    assign level    = lvl_s;
    assign devReady = !full_s;
    assign tcDone   = tc_q;

endmodule

// File: tb/tb_dma_dreq_agent.sv
// Directed bench for dma_dreq_agent (DEPTH=8, THRESH=1): a per-cycle vector table
// for single and demand transfers, plus hand-written full-FIFO, terminal-count,
// polarity and reset sequences.
module tb_dma_dreq_agent;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       dreqActiveLow;
    logic       dackActiveLow;
    logic       demandMode;
    logic       devValid;
    logic [7:0] devData;
    logic       devReady;
    logic       DREQ;
    logic       DACK;
    logic       IOR_N;
    logic       EOP_N;
    logic [7:0] DB;
    logic       DBEn;
    logic [3:0] level;
    logic       tcDone;

    int checks = 0;
    int errors = 0;

    dma_dreq_agent #(.DEPTH(8), .THRESH(1)) dut (
        .CLK(CLK), .RESET(RESET), .dreqActiveLow(dreqActiveLow),
        .dackActiveLow(dackActiveLow), .demandMode(demandMode),
        .devValid(devValid), .devData(devData), .devReady(devReady),
        .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N), .EOP_N(EOP_N),
        .DB(DB), .DBEn(DBEn), .level(level), .tcDone(tcDone)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       dv;
        logic [7:0] dd;
        logic       dm;
        logic       dack;
        logic       ior;
        logic       e_dreq;
        logic       e_dben;
        logic [7:0] e_db;
        logic [3:0] e_lvl;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(logic dv, logic [7:0] dd, logic dm, logic dack, logic ior,
                                logic e_dreq, logic e_dben, logic [7:0] e_db, logic [3:0] e_lvl);
        vec_t v;
        v.dv = dv; v.dd = dd; v.dm = dm; v.dack = dack; v.ior = ior;
        v.e_dreq = e_dreq; v.e_dben = e_dben; v.e_db = e_db; v.e_lvl = e_lvl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET    = 1'b1;
        devValid = 1'b0;
        devData  = 8'h00;
        DACK     = dackActiveLow;
        IOR_N    = 1'b1;
        EOP_N    = 1'b1;
        step();
        step();
        RESET = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        devValid = 1'b1;
        devData  = d;
        step();
        devValid = 1'b0;
    endtask

    // One single-mode read: acknowledge, strobe, release.
    task automatic read_byte(input string name, input logic [7:0] exp);
        DACK = ~dackActiveLow;
        step();
        step();
        IOR_N = 1'b0;
        step();
        chk({name, "_db"}, DB, exp);
        IOR_N = 1'b1;
        step();
        DACK = dackActiveLow;
        step();
    endtask

    initial begin
        dreqActiveLow = 1'b0;
        dackActiveLow = 1'b0;
        demandMode    = 1'b0;
        do_reset();

        // reset state
        chk("rst_dreq", DREQ, 1'b0);
        chk("rst_level", level, 4'd0);
        chk("rst_dben", DBEn, 1'b0);
        chk("rst_db", DB, 8'h00);
        chk("rst_tc", tcDone, 1'b0);
        chk("rst_ready", devReady, 1'b1);

        // single transfer of 0xA5, then demand transfer of 01..04
        vecs[0]  = mk(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd1);
        vecs[1]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd1);
        vecs[2]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd1);
        vecs[3]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd1);
        vecs[4]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd1);
        vecs[5]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
        vecs[6]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
        vecs[7]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
        vecs[8]  = mk(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd1);
        vecs[9]  = mk(1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd2);
        vecs[10] = mk(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd3);
        vecs[11] = mk(1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd4);
        vecs[12] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 4'd4);
        vecs[13] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd3);
        vecs[14] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 4'd3);
        vecs[15] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd2);
        vecs[16] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 4'd2);
        vecs[17] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd1);
        vecs[18] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 4'd1);
        vecs[19] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
        vecs[20] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);

        for (int i = 0; i < 21; i++) begin
            devValid   = vecs[i].dv;
            devData    = vecs[i].dd;
            demandMode = vecs[i].dm;
            DACK       = vecs[i].dack;
            IOR_N      = vecs[i].ior;
            step();
            chk($sformatf("v%0d_dreq", i), DREQ, vecs[i].e_dreq);
            chk($sformatf("v%0d_dben", i), DBEn, vecs[i].e_dben);
            chk($sformatf("v%0d_db", i), DB, vecs[i].e_db);
            chk($sformatf("v%0d_level", i), level, vecs[i].e_lvl);
            chk($sformatf("v%0d_tc", i), tcDone, 1'b0);
        end
        devValid = 1'b0;
        IOR_N    = 1'b1;
        DACK     = 1'b0;

        // full FIFO: nine pushes, ninth dropped; push+pop at full accepted
        demandMode = 1'b0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push(8'h10 + 8'(i));
            if (i == 7) chk("full_ready", devReady, 1'b0);
        end
        chk("full_level", level, 4'd8);
        DACK = 1'b1;
        step();
        step();
        IOR_N = 1'b0;
        step();
        chk("full_db0", DB, 8'h10);
        IOR_N    = 1'b1;
        devValid = 1'b1;
        devData  = 8'hEE;
        step();
        devValid = 1'b0;
        chk("full_pushpop_level", level, 4'd8);
        DACK = 1'b0;
        step();
        for (int i = 1; i < 8; i++) read_byte($sformatf("drain%0d", i), 8'h10 + 8'(i));
        read_byte("drain_new", 8'hEE);
        chk("drain_level", level, 4'd0);

        // terminal count after two demand pops
        demandMode = 1'b1;
        do_reset();
        for (int i = 1; i <= 4; i++) push(8'(i));
        DACK = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            IOR_N = 1'b0;
            step();
            IOR_N = 1'b1;
            step();
        end
        chk("eop_pre_level", level, 4'd2);
        chk("eop_pre_dreq", DREQ, 1'b1);
        EOP_N = 1'b0;
        step();
        EOP_N = 1'b1;
        chk("eop_tc", tcDone, 1'b1);
        chk("eop_dreq", DREQ, 1'b0);
        chk("eop_level", level, 4'd2);
        step();
        chk("eop_tc_clear", tcDone, 1'b0);
        DACK = 1'b0;
        step();
        chk("eop_rel_dreq", DREQ, 1'b0);
        step();
        chk("eop_rereq", DREQ, 1'b1);
        DACK = 1'b1;

        // polarity: both active low
        dreqActiveLow = 1'b1;
        dackActiveLow = 1'b1;
        demandMode    = 1'b0;
        do_reset();
        chk("pol_idle_dreq", DREQ, 1'b1);
        push(8'h5A);
        step();
        chk("pol_req_dreq", DREQ, 1'b0);
        IOR_N = 1'b0;
        step();
        chk("pol_noack_dben", DBEn, 1'b0);
        IOR_N = 1'b1;
        step();
        chk("pol_noack_level", level, 4'd1);
        DACK = 1'b0;
        step();
        IOR_N = 1'b0;
        step();
        chk("pol_ack_dben", DBEn, 1'b1);
        chk("pol_ack_db", DB, 8'h5A);
        IOR_N = 1'b1;
        step();
        chk("pol_ack_level", level, 4'd0);
        chk("pol_rel_dreq", DREQ, 1'b1);
        DACK = 1'b1;
        step();

        // reset mid-transfer with three bytes queued
        dackActiveLow = 1'b0;
        demandMode    = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i));
        DACK = 1'b1;
        step();
        IOR_N = 1'b0;
        step();
        chk("mid_dben", DBEn, 1'b1);
        #2;
        RESET = 1'b1;
        #1;
        chk("mid_rst_dreq", DREQ, 1'b1);
        chk("mid_rst_level", level, 4'd0);
        chk("mid_rst_dben", DBEn, 1'b0);
        chk("mid_rst_db", DB, 8'h00);
        chk("mid_rst_tc", tcDone, 1'b0);
        chk("mid_rst_ready", devReady, 1'b1);
        step();
        DACK  = 1'b0;
        IOR_N = 1'b1;
        RESET = 1'b0;
        step();
        step();
        chk("post_rst_dreq", DREQ, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
